byte_serial_subtractor: RTL

BYTE_SERIAL_SUBTRACTOR -- requirements
Module: byte_serial_subtractor

---
 rtl/byte_serial_subtractor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/byte_serial_subtractor.sv
//------------------------------------------------------------------------------
// byte_serial_subtractor: W-bit A - B - B_in computed one byte slice per clock.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_serial_subtractor #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         B_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] D,
    output logic         B_out,
    output logic         V
);

    localparam int N  = W / 8;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic          borrow_q, borrow_d;
    logic [W-1:0]  d_q, d_d;
    logic          bout_q, bout_d;
    logic          v_q, v_d;

    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic [8:0]    w_slice;
    logic [W-1:0]  w_acc_ins;
    logic          w_last;

    // Slice select and accumulator insert use constant indices only.
    always_comb begin
        w_a_byte  = '0;
        w_b_byte  = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                w_a_byte = a_q[8*i +: 8];
                w_b_byte = b_q[8*i +: 8];
            end
        end
        w_slice   = {1'b0, w_a_byte} - {1'b0, w_b_byte} - {8'd0, borrow_q};
        w_acc_ins = acc_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                w_acc_ins[8*i +: 8] = w_slice[7:0];
            end
        end
        w_last = (k_q == KW'(N - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        v_d      = v_q;
        case (state_q)
            S_RUN: begin
                acc_d    = w_acc_ins;
                borrow_d = w_slice[8];
                if (w_last) begin
                    d_d     = w_acc_ins;
                    bout_d  = w_slice[8];
                    v_d     = (a_q[W-1] != b_q[W-1]) && (w_acc_ins[W-1] != a_q[W-1]);
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = B_in;
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign D     = d_q;
    assign B_out = bout_q;
    assign V     = v_q;

endmodule

`default_nettype wire
